imm_gen_unit: RTL
=================

# imm_gen_unit

Pipelined, parametrised immediate generator for the ID stage. It extracts and extends the immediate for every RV32/RV64 base format, for the CSR zimm and shift-amount fields, and optionally for the RVC CI/CJ/CB formats. It also computes the PC-relative target `pc + imm`. Results are registered behind a valid/ready handshake with a one-entry skid buffer, which gives full throughput under back-pressure. ID-stage flush is supported.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: XLEN. Legal values are 32 and 64; immediates are sign/zero-extended to this width.
- `RVC_EN`, default 1: enables the compressed-format selectors. When 0, those selectors are illegal.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard all held and incoming entries.
- `in_valid_i` in 1: input entry valid.
- `in_ready_o` out 1: block can accept an input.
- `instruction_i` in 32: raw instruction. RVC uses bits [15:0].
- `pc_i` in DATA_WIDTH: PC of the instruction.
- `ImmSel_i` in `imm_sel_e`: format select.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `immediate_o` out DATA_WIDTH: extended immediate.
- `target_o` out DATA_WIDTH: `pc_i + immediate_o`, mod 2^DATA_WIDTH.
- `illegal_o` out 1: selector was unsupported; `immediate_o` is 0 in that case.

## Operation
Format rules (S = sign-extend from the top bit listed, Z = zero-extend):
- ITYPE: S {inst[31:20]}.
- LOGICAL: Z {inst[31:20]}.
- STYPE: S {inst[31:25], inst[11:7]}.
- BTYPE: S {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- UTYPE: S {inst[31:12], 12'b0}. On RV64 the upper 32 bits copy inst[31].
- JTYPE: S {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- ZIMM: Z {inst[19:15]}.
- SHAMT: Z {inst[24:20]} when DATA_WIDTH=32; Z {inst[25:20]} when DATA_WIDTH=64.
- CI (RVC_EN only): S {inst[12], inst[6:2]}.
- CJ (RVC_EN only): S offset[11|4|9:8|10|6|7|3:1|5] = inst[12|11|10:9|8|7|6|5:3|2], with offset[0] = 0.
- CB (RVC_EN only): S offset[8|4:3|7:6|2:1|5] = inst[12|11:10|6:5|4:3|2], with offset[0] = 0.
- Any other encoding, or a CI/CJ/CB selector with RVC_EN=0: `immediate_o` = 0, `illegal_o` = 1, and `target_o` = `pc_i`.

Datapath:
- Decoding and the adder are combinational in front of the output register.
- Storage is two entries: the output register (OR) and the skid register (SK). Each entry holds {imm, target, illegal}.
- `in_ready_o` = !SK.valid, registered-state driven, with no combinational path from `out_ready_i`.

Per-cycle update (flush aside):
- Accept happens when `in_valid_i` && `in_ready_o`.
- Drain happens when `out_valid_o` && `out_ready_i`.
- OR empty or draining: OR loads SK if SK is valid, otherwise OR loads the accepted input; SK then takes the input if both applied.
- OR full and not draining: an accepted input goes to SK.
- Order is strictly FIFO.

Boundary conditions:
- Flush: `flush_i` has priority over everything. OR.valid and SK.valid clear at the next edge. Any input presented in the flush cycle is dropped. `in_ready_o` is 1 the next cycle.
- Accept and drain in the same cycle with SK empty: OR is replaced, throughput is 1 per cycle, and SK stays empty.
- Both entries full: `in_ready_o` = 0 until a drain occurs.
- Data payload registers update only on load. Payload contents are don't-care while the entry is invalid, but the outputs read 0 after reset.

## Timing
- Latency is 1 cycle: input accepted at edge N gives `out_valid_o` = 1 after edge N, when OR was free.
- Reset values: `out_valid_o` = 0, `immediate_o` = 0, `target_o` = 0, `illegal_o` = 0, `in_ready_o` = 1; SK invalid.
- Reset applied mid-stream behaves exactly like flush and additionally zeroes the payload.
- Outputs are stable while `out_valid_o` && !`out_ready_i`.

## Structure
- `core_pkg` holds the `imm_sel_e` enumeration: ITYPE, LOGICAL, STYPE, BTYPE, UTYPE, JTYPE, ZIMM, SHAMT, CI, CJ, CB.
- `core_pkg` also holds a shared entry struct `imm_entry_t` {imm, target, illegal}.
- One sub-module: `imm_decode`, the purely combinational format extractor, parametrised by DATA_WIDTH and RVC_EN, that outputs imm and illegal.
- The adder and the two-entry skid logic live in the top module.

## Test plan
- I-type: `instruction_i` = 0xFFF00093 (ITYPE), `pc_i` = 0x100, `out_ready_i` = 1 → next cycle `immediate_o` = 0xFFFFFFFF, `target_o` = 0x000000FF.
- B-type: `instruction_i` = 0xFE000EE3 (BTYPE), `pc_i` = 0x200 → `immediate_o` = 0xFFFFFFFC, `target_o` = 0x1FC.
- RVC: `instruction_i` = 0x0000BFFD (CJ), RVC_EN=1 → `immediate_o` = 0xFFFFFFFE. Same stimulus with RVC_EN=0 → `illegal_o` = 1, `immediate_o` = 0.
- Back-pressure: send 3 back-to-back ITYPE immediates 1, 2, 3 with `out_ready_i` = 0.
  - After 2 accepts, `in_ready_o` = 0 and the third is held.
  - Raising `out_ready_i` then yields 1, 2, 3 in order on consecutive cycles with no loss.
- Flush: with both entries full, pulse `flush_i` while `in_valid_i` = 1 → next cycle `out_valid_o` = 0 and `in_ready_o` = 1, and the flushed-cycle input never appears.
- RV64 (DATA_WIDTH=64): UTYPE 0x800000B7 → `immediate_o` = 0xFFFFFFFF80000000. SHAMT with inst[25:20] = 63 → `immediate_o` = 63.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared selector and entry types for the immediate generator
package core_pkg;

  typedef enum logic [3:0] {
    ITYPE, LOGICAL, STYPE, BTYPE, UTYPE, JTYPE, ZIMM, SHAMT, CI, CJ, CB
  } imm_sel_e;

  localparam int XLEN_MAX = 64;

  // Sized for RV64 so one type serves both XLENs; RV32 uses the low half.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_unit_if.sv
// rtl/imm_gen_unit_if.sv - input/output handshake bundle of the immediate generator
interface imm_gen_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import core_pkg::*;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           instruction_i;
  logic [DATA_WIDTH-1:0] pc_i;
  imm_sel_e              ImmSel_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] immediate_o;
  logic [DATA_WIDTH-1:0] target_o;
  logic                  illegal_o;

  modport master (
    output in_valid_i, instruction_i, pc_i, ImmSel_i, out_ready_i,
    input  in_ready_o, out_valid_o, immediate_o, target_o, illegal_o
  );

  modport slave (
    input  in_valid_i, instruction_i, pc_i, ImmSel_i, out_ready_i,
    output in_ready_o, out_valid_o, immediate_o, target_o, illegal_o
  );

endinterface

// File: rtl/imm_gen_unit_decode.sv
// rtl/imm_gen_unit_decode.sv - combinational immediate extraction for all formats
module imm_decode
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit RVC_EN     = 1'b1
) (
  input  logic [31:0]           instruction_i,
  input  imm_sel_e              imm_sel_i,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic                  illegal_o
);

  logic [31:0] inst;
  assign inst = instruction_i;

  // Signed casts sign-extend to XLEN; unsigned casts zero-extend.
  always_comb begin
    imm_o     = '0;
    illegal_o = 1'b0;
    case (imm_sel_i)
      ITYPE:   imm_o = DATA_WIDTH'($signed(inst[31:20]));
      LOGICAL: imm_o = DATA_WIDTH'(inst[31:20]);
      STYPE:   imm_o = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      BTYPE:   imm_o = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      UTYPE:   imm_o = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
      JTYPE:   imm_o = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      ZIMM:    imm_o = DATA_WIDTH'(inst[19:15]);
      SHAMT: begin
        if (DATA_WIDTH == 64) imm_o = DATA_WIDTH'(inst[25:20]);
        else                  imm_o = DATA_WIDTH'(inst[24:20]);
      end
      CI: begin
        if (RVC_EN) imm_o = DATA_WIDTH'($signed({inst[12], inst[6:2]}));
        else        illegal_o = 1'b1;
      end
      CJ: begin
        if (RVC_EN) imm_o = DATA_WIDTH'($signed({inst[12], inst[8], inst[10:9], inst[6],
                                                 inst[7], inst[2], inst[11], inst[5:3], 1'b0}));
        else        illegal_o = 1'b1;
      end
      CB: begin
        if (RVC_EN) imm_o = DATA_WIDTH'($signed({inst[12], inst[6:5], inst[2],
                                                 inst[11:10], inst[4:3], 1'b0}));
        else        illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_unit.sv
// rtl/imm_gen_unit.sv - registered immediate generator with PC-relative target and skid buffer
module imm_gen_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit RVC_EN     = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  imm_gen_unit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] dec_imm;
  logic [DATA_WIDTH-1:0] dec_target;
  logic                  dec_illegal;

  imm_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .RVC_EN     (RVC_EN)
  ) u_decode (
    .instruction_i (bus.instruction_i),
    .imm_sel_i     (bus.ImmSel_i),
    .imm_o         (dec_imm),
    .illegal_o     (dec_illegal)
  );

  // Illegal selectors yield imm 0, so the target falls back to the PC.
  assign dec_target = bus.pc_i + dec_imm;

  imm_entry_t in_entry;
  imm_entry_t or_q, or_d, sk_q, sk_d;
  logic       or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
  logic       accept, drain;

  always_comb begin
    in_entry         = '0;
    in_entry.imm     = XLEN_MAX'(dec_imm);
    in_entry.target  = XLEN_MAX'(dec_target);
    in_entry.illegal = dec_illegal;
  end

  assign accept = bus.in_valid_i && !sk_vld_q;
  assign drain  = or_vld_q && bus.out_ready_i;

  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    if (flush_i) begin
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else if (!or_vld_q || drain) begin
      if (sk_vld_q) begin
        or_d     = sk_q;
        or_vld_d = 1'b1;
        sk_vld_d = accept;
        if (accept) sk_d = in_entry;
      end else begin
        or_vld_d = accept;
        if (accept) or_d = in_entry;
      end
    end else if (accept) begin
      sk_d     = in_entry;
      sk_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_vld_q <= 1'b0;
      sk_vld_q <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      sk_vld_q <= sk_vld_d;
      or_q     <= or_d;
      sk_q     <= sk_d;
    end
  end

  assign bus.in_ready_o  = !sk_vld_q;
  assign bus.out_valid_o = or_vld_q;
  assign bus.immediate_o = or_q.imm[DATA_WIDTH-1:0];
  assign bus.target_o    = or_q.target[DATA_WIDTH-1:0];
  assign bus.illegal_o   = or_q.illegal;

  if (DATA_WIDTH < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{or_q.imm[XLEN_MAX-1:DATA_WIDTH], or_q.target[XLEN_MAX-1:DATA_WIDTH]};
  end

endmodule
